// File: rtl/timer_dev.sv
// Memory-mapped countdown timer with IRQ (CTRL / PRESET / COUNT words).
// Optional prescaler on CTRL[15:8] when TIMER_PRESCALE_EN is defined.
module timer_dev #(
  parameter int unsigned   DW           = 32,
  parameter logic [DW-1:0] RESET_PRESET = '0
) (
  input  logic          clk,
  input  logic          reset,
  input  logic [1:0]    Addr,
  input  logic          WE,
  input  logic [DW-1:0] WD,
  output logic [DW-1:0] RD,
  output logic          IRQ
);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_LOAD = 2'd1;
  localparam logic [1:0] S_CNT  = 2'd2;
  localparam logic [1:0] S_INT  = 2'd3;

  logic [1:0]    state_q, state_d;
  logic [DW-1:0] count_q, count_d;
  logic [DW-1:0] preset_q;
  logic          irq_pend_q, irq_pend_d;
  logic          ctrl_en_q, ctrl_en_d;
  logic [1:0]    ctrl_mode_q;
  logic          ctrl_im_q, ctrl_im_d;
  logic [DW-1:0] ctrl_rd;
  logic          wr_ctrl, wr_preset;
  logic          auto_reload;
  logic          en_eff;
  logic          step;

  assign wr_ctrl     = WE && (Addr == 2'd0);
  assign wr_preset   = WE && (Addr == 2'd1);
  assign auto_reload = (ctrl_mode_q == 2'b01);
  assign ctrl_im_d   = wr_ctrl ? WD[3] : ctrl_im_q;
  // A CTRL write landing during CNT is honoured in the same cycle, so a stop freezes the value just read.
  assign en_eff      = wr_ctrl ? WD[0] : ctrl_en_q;

`ifdef TIMER_PRESCALE_EN
  logic [7:0] ctrl_psc_q;
  logic [7:0] psc_cnt_q, psc_cnt_d;

  assign step = (psc_cnt_q == ctrl_psc_q);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      ctrl_psc_q <= 8'd0;
      psc_cnt_q  <= 8'd0;
    end else begin
      if (wr_ctrl) ctrl_psc_q <= WD[15:8];
      psc_cnt_q <= psc_cnt_d;
    end
  end
`else
  assign step = 1'b1;
`endif

  // Next-state, counter and interrupt-pending logic
  always_comb begin
    state_d    = state_q;
    count_d    = count_q;
    irq_pend_d = irq_pend_q;
    ctrl_en_d  = wr_ctrl ? WD[0] : ctrl_en_q;
`ifdef TIMER_PRESCALE_EN
    psc_cnt_d  = psc_cnt_q;
`endif
    if (wr_ctrl || wr_preset) irq_pend_d = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (ctrl_en_q) state_d = S_LOAD;
      end
      S_LOAD: begin
        count_d = preset_q;
        state_d = S_CNT;
`ifdef TIMER_PRESCALE_EN
        psc_cnt_d = 8'd0;
`endif
      end
      S_CNT: begin
        if (!en_eff) begin
          state_d = S_IDLE;
        end else begin
`ifdef TIMER_PRESCALE_EN
          psc_cnt_d = step ? 8'd0 : psc_cnt_q + 8'd1;
`endif
          if (step) begin
            if (count_q > DW'(1)) begin
              count_d = count_q - DW'(1);
            end else begin
              count_d    = '0;
              irq_pend_d = 1'b1;
              state_d    = S_INT;
              // One-shot drops En unless the CPU rewrites CTRL this cycle.
              if (!auto_reload && !wr_ctrl) ctrl_en_d = 1'b0;
            end
          end
        end
      end
      S_INT: begin
        state_d = S_IDLE;
        if (auto_reload) irq_pend_d = 1'b0;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // State and register file
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= S_IDLE;
      count_q     <= '0;
      preset_q    <= RESET_PRESET;
      irq_pend_q  <= 1'b0;
      ctrl_en_q   <= 1'b0;
      ctrl_mode_q <= 2'b00;
      ctrl_im_q   <= 1'b0;
      IRQ         <= 1'b0;
    end else begin
      state_q    <= state_d;
      count_q    <= count_d;
      irq_pend_q <= irq_pend_d;
      ctrl_en_q  <= ctrl_en_d;
      ctrl_im_q  <= ctrl_im_d;
      IRQ        <= irq_pend_d & ctrl_im_d;
      if (wr_ctrl)   ctrl_mode_q <= WD[2:1];
      if (wr_preset) preset_q    <= WD;
    end
  end

  always_comb begin
    ctrl_rd       = '0;
    ctrl_rd[3:0]  = {ctrl_im_q, ctrl_mode_q, ctrl_en_q};
`ifdef TIMER_PRESCALE_EN
    ctrl_rd[15:8] = ctrl_psc_q;
`endif
  end

  // Same-cycle read mux
  always_comb begin
    RD = '0;
    case (Addr)
      2'd0:    RD = ctrl_rd;
      2'd1:    RD = preset_q;
      2'd2:    RD = count_q;
      default: RD = '0;
    endcase
  end

endmodule
